// File: rtl/mem_wb_stage_if.sv
// MEM-stage request bus from EXE_MEM plus stall and MEM/WB register outputs.
interface mem_wb_stage_if;
  logic [31:0] MEM_pc;
  logic [31:0] MEM_b;
  logic [31:0] MEM_c;
  logic [4:0]  MEM_num_write;
  logic        MEM_mem_write;
  logic        MEM_reg_write;
  logic [1:0]  MEM_s_data_write;
  logic        mem_stall;
  logic [31:0] WB_pc;
  logic [31:0] WB_data;
  logic [4:0]  WB_num_write;
  logic        WB_reg_write;

  // Upstream pipeline side: drives the request, observes stall and WB outputs.
  modport master (
    output MEM_pc, MEM_b, MEM_c, MEM_num_write, MEM_mem_write, MEM_reg_write, MEM_s_data_write,
    input  mem_stall, WB_pc, WB_data, WB_num_write, WB_reg_write
  );

  // MEM stage side.
  modport slave (
    input  MEM_pc, MEM_b, MEM_c, MEM_num_write, MEM_mem_write, MEM_reg_write, MEM_s_data_write,
    output mem_stall, WB_pc, WB_data, WB_num_write, WB_reg_write
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage with multi-cycle data RAM access and the MEM/WB pipeline register.
module mem_wb_stage #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned MEM_LAT = 3
) (
  input  logic           clock,
  input  logic           reset,
  mem_wb_stage_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 3;
  localparam bit          MULTI = (MEM_LAT > 1);

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] b;
    logic [31:0] c;
    logic [4:0]  num;
    logic        mem_write;
    logic        reg_write;
    logic [1:0]  s;
  } req_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  req_t               in_req;
  req_t               lat_req;
  req_t               cmt_req;
  logic               acc;
  logic               commit;
  logic               ram_we;
  logic [ADDR_W-1:0]  cmt_idx;
  logic [31:0]        rdata;
  logic [31:0]        wb_val;
  logic [31:0]        ram [DEPTH];

  // Gather the incoming EXE_MEM fields into one request word.
  always_comb begin
    in_req.pc        = bus.MEM_pc;
    in_req.b         = bus.MEM_b;
    in_req.c         = bus.MEM_c;
    in_req.num       = bus.MEM_num_write;
    in_req.mem_write = bus.MEM_mem_write;
    in_req.reg_write = bus.MEM_reg_write;
    in_req.s         = bus.MEM_s_data_write;
  end

  // Commit decision, stall and write-back value selection.
  always_comb begin
    acc     = in_req.mem_write | (in_req.s == 2'b01);
    cmt_req = (state == BUSY) ? lat_req : in_req;
    if (state == BUSY) begin
      commit        = (cnt == CNT_W'(1));
      bus.mem_stall = reset & (cnt > CNT_W'(1));
    end else begin
      commit        = ~(acc & MULTI);
      bus.mem_stall = reset & acc & MULTI;
    end
    ram_we  = reset & commit & cmt_req.mem_write;
    cmt_idx = cmt_req.c[ADDR_W+1:2];
    rdata   = ram[cmt_idx];
    case (cmt_req.s)
      2'b01:   wb_val = rdata;
      2'b10:   wb_val = cmt_req.pc + 32'd4;
      default: wb_val = cmt_req.c;
    endcase
  end

  // Data RAM write port; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram[cmt_idx] <= cmt_req.b;
    end
  end

  // Access FSM, latched request and MEM/WB register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      cnt              <= '0;
      lat_req          <= '0;
      bus.WB_pc        <= '0;
      bus.WB_data      <= '0;
      bus.WB_num_write <= '0;
      bus.WB_reg_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc && MULTI) begin
            state   <= BUSY;
            cnt     <= CNT_W'(MEM_LAT - 1);
            lat_req <= in_req;
          end
        end
        BUSY: begin
          if (cnt > CNT_W'(1)) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      if (commit) begin
        bus.WB_pc        <= cmt_req.pc;
        bus.WB_data      <= wb_val;
        bus.WB_num_write <= cmt_req.num;
        bus.WB_reg_write <= cmt_req.reg_write & ~cmt_req.mem_write;
      end else begin
        bus.WB_reg_write <= 1'b0;
      end
    end
  end

endmodule
